// File: rtl/aes_128_pkg.sv
// Shared constants and FSM encoding for the AES-128 round-key RAM scheduler.
package aes_128_pkg;

   localparam int NUM_ROUNDS = 11;
   localparam int LENGTH_RAM = 22;
   localparam int ADDR_W     = 5;

   // Highest legal round index; anything above is refused with err.
   localparam logic [3:0] MAX_ROUND = 4'(NUM_ROUNDS - 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_LO   = 3'd1,
      WR_HI   = 3'd2,
      RD_LO   = 3'd3,
      RD_HI   = 3'd4,
      RD_DONE = 3'd5
   } state_t;

   // Each round key occupies two consecutive 64-bit words: even = low half, odd = high half.
   function automatic logic [ADDR_W-1:0] word_addr(input logic [3:0] round, input logic hi);
      return {round, hi};
   endfunction

endpackage

// File: rtl/aes_128_keyram_sched.sv
// Round-key RAM owner: writes expanded keys as two 64-bit words, serves
// 128-bit fetches once all rounds are loaded. Writes win over reads.
module aes_128_keyram_sched
   import aes_128_pkg::*;
(
   input  logic              clk,
   input  logic              kill_n,
   input  logic              kexp_valid,
   input  logic [3:0]        kexp_round,
   input  logic [127:0]      kexp_key,
   output logic              kexp_ready,
   input  logic              flush,
   input  logic              rd_req,
   input  logic [3:0]        rd_round,
   output logic              rd_ready,
   output logic              rd_valid,
   output logic [127:0]      rd_key,
   output logic              err,
   output logic              keys_ready,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [63:0]       ram_din,
   input  logic [63:0]       ram_dout
);

   state_t                 state_q, state_d;
   logic [3:0]             round_q, round_d;
   logic [127:0]           key_q, key_d;
   logic [63:0]            lo_buf_q, lo_buf_d;
   logic [127:0]           rd_key_q, rd_key_d;
   logic                   rd_valid_q, rd_valid_d;
   logic                   err_q, err_d;
   logic [NUM_ROUNDS-1:0]  valid_map_q, valid_map_d;

   assign kexp_ready = (state_q == IDLE);
   assign keys_ready = &valid_map_q;
   assign rd_ready   = (state_q == IDLE) & ~kexp_valid & keys_ready;
   assign rd_valid   = rd_valid_q;
   assign rd_key     = rd_key_q;
   assign err        = err_q;

   // Next-state, handshake acceptance and valid-map bookkeeping.
   always_comb begin
      state_d     = state_q;
      round_d     = round_q;
      key_d       = key_q;
      lo_buf_d    = lo_buf_q;
      rd_key_d    = rd_key_q;
      rd_valid_d  = 1'b0;
      err_d       = 1'b0;
      valid_map_d = valid_map_q;
      case (state_q)
         IDLE: begin
            if (kexp_valid) begin
               if (kexp_round > MAX_ROUND) begin
                  err_d = 1'b1;
               end else begin
                  round_d = kexp_round;
                  key_d   = kexp_key;
                  state_d = WR_LO;
                  // Round 0 marks the start of a fresh key schedule.
                  if (kexp_round == 4'd0) valid_map_d = '0;
               end
            end else if (rd_req && rd_ready) begin
               if (rd_round > MAX_ROUND) begin
                  err_d = 1'b1;
               end else begin
                  round_d = rd_round;
                  state_d = RD_LO;
               end
            end
         end
         WR_LO:   state_d = WR_HI;
         WR_HI: begin
            valid_map_d[round_q] = 1'b1;
            state_d              = IDLE;
         end
         RD_LO:   state_d = RD_HI;
         RD_HI: begin
            // ram_dout now carries the even (low) word addressed in RD_LO.
            lo_buf_d = ram_dout;
            state_d  = RD_DONE;
         end
         RD_DONE: begin
            rd_key_d   = {ram_dout, lo_buf_q};
            rd_valid_d = 1'b1;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Flush wins over any bit being set by a completing write.
      if (flush) valid_map_d = '0;
   end

   // RAM port is a pure decode of the registered state so the address lines
   // line up with the one-cycle RAM read latency.
   always_comb begin
      ram_en   = 1'b0;
      ram_we   = 1'b0;
      ram_addr = '0;
      ram_din  = '0;
      case (state_q)
         WR_LO: begin
            ram_en   = 1'b1;
            ram_we   = 1'b1;
            ram_addr = word_addr(round_q, 1'b0);
            ram_din  = key_q[63:0];
         end
         WR_HI: begin
            ram_en   = 1'b1;
            ram_we   = 1'b1;
            ram_addr = word_addr(round_q, 1'b1);
            ram_din  = key_q[127:64];
         end
         RD_LO: begin
            ram_en   = 1'b1;
            ram_addr = word_addr(round_q, 1'b0);
         end
         RD_HI: begin
            ram_en   = 1'b1;
            ram_addr = word_addr(round_q, 1'b1);
         end
         default: ;
      endcase
   end

   // State registers; kill_n abandons any partial transfer immediately.
   always_ff @(posedge clk or negedge kill_n) begin
      if (!kill_n) begin
         state_q     <= IDLE;
         round_q     <= '0;
         key_q       <= '0;
         lo_buf_q    <= '0;
         rd_key_q    <= '0;
         rd_valid_q  <= 1'b0;
         err_q       <= 1'b0;
         valid_map_q <= '0;
      end else begin
         state_q     <= state_d;
         round_q     <= round_d;
         key_q       <= key_d;
         lo_buf_q    <= lo_buf_d;
         rd_key_q    <= rd_key_d;
         rd_valid_q  <= rd_valid_d;
         err_q       <= err_d;
         valid_map_q <= valid_map_d;
      end
   end

endmodule

// File: tb/tb_aes_128_keyram_sched.sv
// Directed bench for aes_128_keyram_sched with a behavioural 32x64 RAM.
module tb_aes_128_keyram_sched;

   logic         clk = 1'b0;
   logic         kill_n, kexp_valid, flush, rd_req;
   logic [3:0]   kexp_round, rd_round;
   logic [127:0] kexp_key;
   logic         kexp_ready, rd_ready, rd_valid, err, keys_ready;
   logic         ram_en, ram_we;
   logic [4:0]   ram_addr;
   logic [63:0]  ram_din;
   logic [63:0]  ram_dout = '0;
   logic [127:0] rd_key;

   aes_128_keyram_sched dut (
      .clk(clk), .kill_n(kill_n),
      .kexp_valid(kexp_valid), .kexp_round(kexp_round), .kexp_key(kexp_key), .kexp_ready(kexp_ready),
      .flush(flush),
      .rd_req(rd_req), .rd_round(rd_round), .rd_ready(rd_ready),
      .rd_valid(rd_valid), .rd_key(rd_key), .err(err), .keys_ready(keys_ready),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
   );

   always #5 clk = ~clk;

   // RAM model and activity counters
   logic [63:0] mem [0:31];
   int          wr_cnt = 0, rd_acc = 0, err_cnt = 0, vld_cnt = 0;
   logic        addr_oob = 1'b0;
   logic [4:0]  ra0 = '0, ra1 = '0;

   always @(posedge clk) begin
      if (ram_en && ram_we) begin
         mem[ram_addr] <= ram_din;
         wr_cnt        <= wr_cnt + 1;
      end
      if (ram_en && !ram_we) begin
         ram_dout <= mem[ram_addr];
         rd_acc   <= rd_acc + 1;
         ra0      <= ra1;
         ra1      <= ram_addr;
      end
      if (ram_en && ram_addr >= 5'd22) addr_oob <= 1'b1;
      if (err)      err_cnt <= err_cnt + 1;
      if (rd_valid) vld_cnt <= vld_cnt + 1;
   end

   int total = 0, bad = 0;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] key_of(input int r);
      logic [63:0] hi, lo;
      hi = 64'hA0 + 64'(r);
      lo = 64'hB0 + 64'(r);
      return {hi, lo};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one round key, wait for acceptance, then for the FSM to return to IDLE.
   task automatic wr(input int r, input logic [127:0] k);
      int n;
      kexp_valid = 1'b1;
      kexp_round = 4'(r);
      kexp_key   = k;
      #1;
      n = 0;
      while (!kexp_ready && n < 20) begin
         tick();
         n++;
      end
      if (n >= 20) chk("wr_accept_timeout", 128'(n), 128'(0));
      tick();
      kexp_valid = 1'b0;
      tick();
      tick();
   endtask

   // Request a round key; lat is the cycle index after the accept edge where rd_valid is seen.
   task automatic rd_wait(input int r, output logic [127:0] k, output int lat);
      int n;
      rd_req   = 1'b1;
      rd_round = 4'(r);
      #1;
      n = 0;
      while (!rd_ready && n < 60) begin
         tick();
         n++;
      end
      if (n >= 60) chk("rd_accept_timeout", 128'(n), 128'(0));
      tick();
      rd_req = 1'b0;
      lat = 1;
      while (!rd_valid && lat < 10) begin
         tick();
         lat++;
      end
      k = rd_key;
   endtask

   initial begin
      logic [127:0] k;
      int           lat, n, e0, a0, v0;

      kill_n = 1'b0; kexp_valid = 1'b0; flush = 1'b0; rd_req = 1'b0;
      kexp_round = '0; rd_round = '0; kexp_key = '0;
      tick();
      tick();
      chk("rst_ram_en",     128'(ram_en),     128'(0));
      chk("rst_ram_we",     128'(ram_we),     128'(0));
      chk("rst_ram_addr",   128'(ram_addr),   128'(0));
      chk("rst_ram_din",    128'(ram_din),    128'(0));
      chk("rst_rd_valid",   128'(rd_valid),   128'(0));
      chk("rst_rd_key",     rd_key,           128'(0));
      chk("rst_err",        128'(err),        128'(0));
      chk("rst_keys_ready", 128'(keys_ready), 128'(0));
      chk("rst_kexp_ready", 128'(kexp_ready), 128'(1));
      kill_n = 1'b1;
      tick();

      // Read held from before the load; it must wait for all 11 rounds.
      rd_req   = 1'b1;
      rd_round = 4'd5;
      for (int r = 0; r < 11; r++) begin
         wr(r, key_of(r));
         if (r == 4) chk("rd_ready_partial", 128'(rd_ready), 128'(0));
      end
      chk("load_wr_cnt",     128'(wr_cnt),     128'(22));
      chk("load_no_reads",   128'(rd_acc),     128'(0));
      chk("load_keys_ready", 128'(keys_ready), 128'(1));
      for (int r = 0; r < 11; r++) begin
         chk("mem_lo", 128'(mem[2*r]),   128'(64'hB0 + 64'(r)));
         chk("mem_hi", 128'(mem[2*r+1]), 128'(64'hA0 + 64'(r)));
      end

      rd_wait(5, k, lat);
      chk("rd5_latency", 128'(lat), 128'(4));
      chk("rd5_key",     k,         {64'hA5, 64'hB5});
      chk("rd5_addr_lo", 128'(ra0), 128'(10));
      chk("rd5_addr_hi", 128'(ra1), 128'(11));
      tick(); tick(); tick();
      chk("rd5_key_hold", rd_key,        {64'hA5, 64'hB5});
      chk("rd5_vld_once", 128'(vld_cnt), 128'(1));

      // Write and read together: write first, read accepted on the third edge after.
      kexp_valid = 1'b1; kexp_round = 4'd3; kexp_key = key_of(3);
      rd_req = 1'b1; rd_round = 4'd3;
      #1;
      chk("both_rd_ready", 128'(rd_ready),   128'(0));
      chk("both_wr_ready", 128'(kexp_ready), 128'(1));
      tick();
      kexp_valid = 1'b0;
      n = 1;
      while (!rd_ready && n < 20) begin
         tick();
         n++;
      end
      chk("both_rd_delay", 128'(n), 128'(3));
      rd_wait(3, k, lat);
      chk("both_rd_key", k, key_of(3));
      chk("both_rd_lat", 128'(lat), 128'(4));

      // Out-of-range write round.
      e0 = err_cnt; a0 = wr_cnt + rd_acc;
      kexp_valid = 1'b1; kexp_round = 4'd11; kexp_key = '1;
      tick();
      kexp_valid = 1'b0;
      chk("wr11_err",    128'(err),        128'(1));
      chk("wr11_ram_en", 128'(ram_en),     128'(0));
      chk("wr11_idle",   128'(kexp_ready), 128'(1));
      tick();
      chk("wr11_err_off", 128'(err), 128'(0));
      tick();
      chk("wr11_err_cnt", 128'(err_cnt - e0),          128'(1));
      chk("wr11_no_ram",  128'(wr_cnt + rd_acc - a0), 128'(0));

      // Out-of-range read round.
      e0 = err_cnt;
      rd_req = 1'b1; rd_round = 4'd12;
      #1;
      chk("rd12_ready", 128'(rd_ready), 128'(1));
      tick();
      rd_req = 1'b0;
      chk("rd12_err",    128'(err),      128'(1));
      chk("rd12_ram_en", 128'(ram_en),   128'(0));
      chk("rd12_idle",   128'(rd_ready), 128'(1));
      tick();
      tick();
      chk("rd12_err_cnt", 128'(err_cnt - e0),          128'(1));
      chk("rd12_no_ram",  128'(wr_cnt + rd_acc - a0), 128'(0));

      // Reload with a flush landing on the final WR_HI.
      wr(0, key_of(0));
      chk("reload_drop", 128'(keys_ready), 128'(0));
      for (int r = 1; r < 10; r++) wr(r, key_of(r));
      kexp_valid = 1'b1; kexp_round = 4'd10; kexp_key = key_of(10);
      tick();
      kexp_valid = 1'b0;
      tick();
      chk("flush_in_wr_hi", 128'(ram_addr), 128'(21));
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush_keys_ready", 128'(keys_ready), 128'(0));
      chk("flush_rd_ready",   128'(rd_ready),   128'(0));
      wr(10, key_of(10));
      chk("flush_cleared_all", 128'(keys_ready), 128'(0));
      for (int r = 0; r < 11; r++) wr(r, key_of(r));
      chk("reload_keys_ready", 128'(keys_ready), 128'(1));

      // kill_n during RD_HI: read is abandoned.
      rd_req = 1'b1; rd_round = 4'd5;
      #1;
      tick();
      rd_req = 1'b0;
      tick();
      chk("kill_in_rd_hi", 128'(ram_addr), 128'(11));
      v0 = vld_cnt;
      kill_n = 1'b0;
      #1;
      chk("kill_rd_valid",   128'(rd_valid),   128'(0));
      chk("kill_rd_key",     rd_key,           128'(0));
      chk("kill_err",        128'(err),        128'(0));
      chk("kill_ram_en",     128'(ram_en),     128'(0));
      chk("kill_ram_we",     128'(ram_we),     128'(0));
      chk("kill_ram_addr",   128'(ram_addr),   128'(0));
      chk("kill_ram_din",    128'(ram_din),    128'(0));
      chk("kill_keys_ready", 128'(keys_ready), 128'(0));
      chk("kill_rd_ready",   128'(rd_ready),   128'(0));
      tick();
      tick();
      kill_n = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      chk("kill_no_rd_valid", 128'(vld_cnt - v0), 128'(0));
      chk("kill_key_zero",    rd_key,             128'(0));
      chk("addr_in_range",    128'(addr_oob),     128'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
